// File: rtl/trace_types_pkg.sv
// ============================================================================
// Module      : trace_types_pkg
// Description : Shared trace element types, EX log entry and tracker FSM states.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package trace_types_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  typedef logic signed [31:0] time_t;

  localparam time_t NO_TIME = -32'sd1;

  typedef struct packed {
    time_t time_start;
    time_t time_end;
  } stage_data_t;

  typedef struct packed {
    time_t              time_start;
    time_t              time_end;
    logic               mem_access;
    logic [ADDR_W-1:0]  mem_addr;
  } ex_data_t;

  typedef struct packed {
    time_t              time_stamp;
    logic               mem_access;
    logic [ADDR_W-1:0]  mem_addr;
  } ex_log_entry_t;

  typedef struct packed {
    stage_data_t        if_data;
    stage_data_t        id_data;
    ex_data_t           ex_data;
    stage_data_t        wb_data;
    logic               pass_through;
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } trace_output_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SEARCH = 2'd2,
    S_OUTPUT = 2'd3
  } ex_state_e;

  function automatic time_t max_time(input time_t a, input time_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_event_log.sv
// ============================================================================
// Module      : ex_event_log
// Description : Circular log of EX-completion events; overwrites oldest when full.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ex_event_log
  import trace_types_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  ex_log_entry_t push_entry,
  input  logic          pop,
  output ex_log_entry_t head,
  output logic          empty,
  output logic          full,
  output logic          overflow
);

  localparam int             c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_aw:0]  c_depth = (c_aw + 1)'(DEPTH);

  ex_log_entry_t    r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr;
  logic [c_aw-1:0]  r_rd;
  logic [c_aw:0]    r_count;

  logic w_pop;
  logic w_overwrite;

  assign empty       = (r_count == '0);
  assign full        = (r_count == c_depth);
  assign head        = r_mem[r_rd];
  assign w_pop       = pop && !empty;
  // A simultaneous pop frees the oldest slot, so only a push without pop loses data
  assign w_overwrite = push && full && !w_pop;

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop || w_overwrite) begin
        r_rd <= r_rd + 1'b1;
      end
      if (push && !w_pop && !full) begin
        r_count <= r_count + 1'b1;
      end else if (!push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_overwrite) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_tracker.sv
// ============================================================================
// Module      : ex_tracker
// Description : Fills the ex_data window of trace elements from a live EX log.
//               Optional data-memory capture enabled by macro EX_MEM_TRACK_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ex_tracker
  import trace_types_pkg::*;
#(
  parameter int  INSTR_DATA_WIDTH  = 32,
  parameter int  DATA_ADDR_WIDTH   = 32,
  parameter int  TRACE_BUFFER_SIZE = 32,
  parameter int  HIST_DEPTH        = 128,
  parameter type trace_output      = trace_output_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [31:0]         counter,
  input  logic                       id_data_ready,
  input  trace_output                id_data_i,
  input  logic                       ex_valid,
  input  logic                       ex_ready,
  input  logic                       data_mem_req,
  input  logic                       data_mem_gnt,
  input  logic [DATA_ADDR_WIDTH-1:0] data_mem_addr,
  output trace_output                ex_data_o,
  output logic                       ex_data_ready,
  output logic                       overflow
);

  localparam int               c_faw        = (TRACE_BUFFER_SIZE > 1) ? $clog2(TRACE_BUFFER_SIZE) : 1;
  localparam int               c_fcw        = $clog2(TRACE_BUFFER_SIZE + 1);
  localparam logic [c_faw-1:0] c_fifo_last  = c_faw'(TRACE_BUFFER_SIZE - 1);
  localparam logic [c_fcw-1:0] c_fifo_depth = c_fcw'(TRACE_BUFFER_SIZE);

  ex_state_e         r_state;
  trace_output       r_elem;
  time_t             r_start;
  time_t             r_prev_ex_end;

  trace_output       r_fifo [TRACE_BUFFER_SIZE];
  logic [c_faw-1:0]  r_fifo_wr;
  logic [c_faw-1:0]  r_fifo_rd;
  logic [c_fcw-1:0]  r_fifo_count;
  logic              r_fifo_ovf;

  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_fifo_pop;
  logic              w_fifo_push;

  logic              w_log_push;
  logic              w_log_pop;
  logic              w_log_empty;
  logic              w_log_full_unused;
  logic              w_log_ovf;
  ex_log_entry_t     w_log_entry;
  ex_log_entry_t     w_log_head;
  logic              w_mem_access;
  logic [ADDR_W-1:0] w_mem_addr;

  logic [INSTR_DATA_WIDTH-1:0] w_unused_instr;
  assign w_unused_instr = INSTR_DATA_WIDTH'(ex_data_o.instr);

  // ---------------------------------------------------------------- input FIFO
  assign w_fifo_empty = (r_fifo_count == '0);
  assign w_fifo_full  = (r_fifo_count == c_fifo_depth);
  assign w_fifo_pop   = (r_state == S_IDLE) && !w_fifo_empty;
  assign w_fifo_push  = id_data_ready && (!w_fifo_full || w_fifo_pop);

  always_ff @(posedge clk) begin
    if (w_fifo_push) begin
      r_fifo[r_fifo_wr] <= id_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_wr    <= '0;
      r_fifo_rd    <= '0;
      r_fifo_count <= '0;
      r_fifo_ovf   <= 1'b0;
    end else begin
      if (w_fifo_push) begin
        r_fifo_wr <= (r_fifo_wr == c_fifo_last) ? '0 : r_fifo_wr + 1'b1;
      end
      if (w_fifo_pop) begin
        r_fifo_rd <= (r_fifo_rd == c_fifo_last) ? '0 : r_fifo_rd + 1'b1;
      end
      if (w_fifo_push && !w_fifo_pop) begin
        r_fifo_count <= r_fifo_count + 1'b1;
      end else if (!w_fifo_push && w_fifo_pop) begin
        r_fifo_count <= r_fifo_count - 1'b1;
      end
      if (id_data_ready && !w_fifo_push) begin
        r_fifo_ovf <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------ memory access capture
`ifdef EX_MEM_TRACK_EN
  logic              r_cap_valid;
  logic [ADDR_W-1:0] r_cap_addr;
  logic              w_mem_hit;

  assign w_mem_hit    = data_mem_req && data_mem_gnt;
  // A grant landing in the completion cycle belongs to that completion
  assign w_mem_access = r_cap_valid || w_mem_hit;
  assign w_mem_addr   = w_mem_hit ? ADDR_W'(data_mem_addr) : r_cap_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_valid <= 1'b0;
      r_cap_addr  <= '0;
    end else if (w_log_push) begin
      r_cap_valid <= 1'b0;
      r_cap_addr  <= '0;
    end else if (w_mem_hit) begin
      r_cap_valid <= 1'b1;
      r_cap_addr  <= ADDR_W'(data_mem_addr);
    end
  end
`else
  logic w_unused_mem;
  assign w_unused_mem = ^{data_mem_req, data_mem_gnt, data_mem_addr};
  assign w_mem_access = 1'b0;
  assign w_mem_addr   = '0;
`endif

  // ------------------------------------------------------------- EX event log
  assign w_log_push  = ex_valid && ex_ready;
  assign w_log_pop   = (r_state == S_SEARCH) && !w_log_empty;
  assign w_log_entry = '{time_stamp: counter, mem_access: w_mem_access, mem_addr: w_mem_addr};

  ex_event_log #(
    .DEPTH (HIST_DEPTH)
  ) u_event_log (
    .clk        (clk),
    .rst        (rst),
    .push       (w_log_push),
    .push_entry (w_log_entry),
    .pop        (w_log_pop),
    .head       (w_log_head),
    .empty      (w_log_empty),
    .full       (w_log_full_unused),
    .overflow   (w_log_ovf)
  );

  assign overflow = r_fifo_ovf || w_log_ovf;

  // ---------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_elem        <= '0;
      r_start       <= '0;
      r_prev_ex_end <= NO_TIME;
      ex_data_o     <= '0;
      ex_data_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ex_data_ready <= 1'b0;
          if (!w_fifo_empty) begin
            r_elem  <= r_fifo[r_fifo_rd];
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_start <= max_time(r_elem.id_data.time_end + 32'sd1, r_prev_ex_end + 32'sd1);
          if (r_elem.pass_through) begin
            r_elem.ex_data <= '0;
            r_elem.wb_data <= '0;
            r_state        <= S_OUTPUT;
          end else begin
            r_state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          // Entries older than the window start belong to earlier elements
          if (!w_log_empty && (w_log_head.time_stamp >= r_start)) begin
            r_elem.ex_data <= '{time_start: r_start,
                                time_end:   w_log_head.time_stamp,
                                mem_access: w_log_head.mem_access,
                                mem_addr:   w_log_head.mem_addr};
            r_prev_ex_end  <= w_log_head.time_stamp;
            r_state        <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          ex_data_o     <= r_elem;
          ex_data_ready <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
